// File: rtl/spm_pkg.sv
// Shared types and sizing constants for the serial-parallel multiplier sequencer.
package spm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } spm_state_e;

  localparam int unsigned SPM_WIDTH = 32;
  // Counter has to reach 2*WIDTH inclusive.
  localparam int unsigned SPM_CNT_W = $clog2(2 * SPM_WIDTH + 1);

endpackage

// File: rtl/spm_deser.sv
// Collects the serial product stream, LSB first, into a parallel word.
module spm_deser #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] prod_q;

  // Clear on a new operation; otherwise shift each returned bit in at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (clr_i) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= {bit_i, prod_q[2*WIDTH-1:1]};
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/spm_seq.sv
// Sequencer driving an external serial-parallel multiplier and assembling its product.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for an operand pair, multiplier outputs parked at 0
// ST_CLEAR | one cycle with spm_rst_n low to clear the multiplier stage
// ST_RUN   | cnt 0..2*WIDTH: stream multiplier bits out, product bits in
// ST_DONE  | prod valid and held until out_ready
module spm_seq
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_rst_n,
  input  logic               spm_p,
  output logic [2*WIDTH-1:0] prod,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = $clog2(2 * WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH);
  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  spm_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [WIDTH-1:0]   mc_q;
  logic [WIDTH-1:0]   mp_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               spm_y_q;
  logic               spm_rst_n_q;
  logic               accept;
  logic               cap_en;
  logic               y_d;
  logic [2*WIDTH-1:0] mp_ext;

  assign accept = (state_q == ST_IDLE) && in_ready_q && in_valid;
  // The first returned bit is only meaningful one cycle after cnt=0.
  assign cap_en = (state_q == ST_RUN) && (cnt_q != '0);
  assign cnt_d  = (state_q == ST_RUN) ? cnt_q + CW'(1) : '0;
  assign mp_ext = {{WIDTH{mp_q[WIDTH-1]}}, mp_q};
  // Shifting past the top bit yields 0, which is exactly the spm_y wanted at cnt=2*WIDTH.
  assign y_d    = |(mp_ext & (ONE << cnt_d));

  // Control FSM; every output is registered from the upcoming state so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      spm_y_q     <= 1'b0;
      spm_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          spm_rst_n_q <= 1'b1;
          if (accept) begin
            state_q     <= ST_CLEAR;
            mc_q        <= mc;
            mp_q        <= mp;
            in_ready_q  <= 1'b0;
            spm_rst_n_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_RUN;
          cnt_q       <= '0;
          spm_rst_n_q <= 1'b1;
          spm_y_q     <= y_d;
        end
        ST_RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            spm_y_q     <= 1'b0;
          end else begin
            cnt_q   <= cnt_d;
            spm_y_q <= y_d;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            mc_q        <= '0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spm_deser #(.WIDTH(WIDTH)) u_deser (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (cap_en),
    .bit_i  (spm_p),
    .prod_o (prod)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign spm_x     = mc_q;
  assign spm_y     = spm_y_q;
  assign spm_rst_n = spm_rst_n_q;

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq paired with a behavioural serial-parallel multiplier.
module tb_spm_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   mc = '0;
  logic [W-1:0]   mp = '0;
  logic           in_ready;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_rst_n;
  logic           spm_p;
  logic [2*W-1:0] prod;
  logic           out_valid;

  int total = 0;
  int bad = 0;
  int clr_cycles = 0;
  logic ov_seen = 1'b0;

  spm_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mc        (mc),
    .mp        (mp),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_rst_n (spm_rst_n),
    .spm_p     (spm_p),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Serial-parallel multiplier: accumulate y*x, emit the settled LSB, shift right.
  logic signed [2*W+1:0] acc;
  logic signed [2*W+1:0] sum;
  logic                  p_q;
  always @(posedge clk or negedge spm_rst_n) begin
    if (!spm_rst_n) begin
      acc <= '0;
      p_q <= 1'b0;
    end else begin
      sum = acc + (spm_y ? {{(W+2){spm_x[W-1]}}, spm_x} : '0);
      p_q <= sum[0];
      acc <= sum >>> 1;
    end
  end
  assign spm_p = p_q;

  always @(negedge clk) begin
    if (rst_n && !spm_rst_n) clr_cycles++;
    if (out_valid) ov_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Called #1 after the accepting edge; the accepting edge counts as edge 1.
  task automatic wait_result(input logic [63:0] exp);
    int edges;
    edges = 1;
    while (!out_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", 64'(edges), 64'(2*W+3));
    chk("prod", prod, exp);
    chk("clr_cycles", 64'(clr_cycles), 64'd1);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic keep_valid);
    int n;
    n = 0;
    @(negedge clk);
    mc = a; mp = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    clr_cycles = 0;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    chk("spm_x_latch", 64'(spm_x), 64'(a));
    wait_result(ref_mul(a, b));
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_spm_x", 64'(spm_x), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    int r;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    r = int'($urandom_range(0, 7));
    if (r < 5) return corners[r];
    return W'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int n;

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_spm_rst_n", 64'(spm_rst_n), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_spm_x", 64'(spm_x), 64'd0);
    chk("rst_spm_y", 64'(spm_y), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_spm_rst_n", 64'(spm_rst_n), 64'd1);

    // Directed products.
    do_op(32'd5, 32'd3, 1'b0);
    chk("p5x3", prod, 64'h0000_0000_0000_000F);
    release_done();
    do_op(32'd50, -32'sd50, 1'b0);
    chk("p50xm50", prod, 64'hFFFF_FFFF_FFFF_F63C);
    release_done();
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("pminxmin", prod, 64'h4000_0000_0000_0000);
    release_done();

    // Hold the result with in_valid asserted throughout.
    e = ref_mul(32'h1234_5678, 32'hFFFF_0003);
    do_op(32'h1234_5678, 32'hFFFF_0003, 1'b1);
    mc = 32'h0000_0011;
    mp = 32'h0000_0002;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_prod", prod, e);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_rel_idle", 64'(in_ready), 64'd1);
    chk("hold_rel_valid", 64'(out_valid), 64'd0);
    clr_cycles = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_reaccept", 64'(in_ready), 64'd0);
    chk("hold_reaccept_x", 64'(spm_x), 64'h11);
    wait_result(ref_mul(32'h11, 32'h2));
    release_done();

    // Reset in the middle of RUN at cnt=20.
    @(negedge clk);
    mc = 32'd123; mp = 32'd456; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ov_seen = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_spm_rst_n", 64'(spm_rst_n), 64'd0);
    chk("midrst_prod", prod, 64'd0);
    chk("midrst_spm_x", 64'(spm_x), 64'd0);
    chk("midrst_spm_y", 64'(spm_y), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_rel_spm_rst_n", 64'(spm_rst_n), 64'd1);
    repeat (70) @(posedge clk);
    #1;
    chk("midrst_no_valid", 64'(ov_seen), 64'd0);
    do_op(32'd7, 32'hFFFF_FFFF, 1'b0);
    chk("p7xm1", prod, 64'hFFFF_FFFF_FFFF_FFF9);
    release_done();

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    do_op(pick(), pick(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = pick();
      b = pick();
      mc = a; mp = b; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_idle", 64'(in_ready), 64'd1);
      chk("b2b_done_drop", 64'(out_valid), 64'd0);
      clr_cycles = 0;
      @(posedge clk); #1;
      chk("b2b_accept", 64'(in_ready), 64'd0);
      chk("b2b_clear", 64'(spm_rst_n), 64'd0);
      in_valid = 1'b0;
      wait_result(ref_mul(a, b));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomized operands with random idle gaps and consumer delays.
    for (int i = 0; i < 16; i++) begin
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(a, b, 1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      e = ref_mul(a, b);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold", prod, e);
      end
      release_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_seq.md
SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the sequencer accepts an operand pair.
REQ-006 SHALL have port mc, input, WIDTH bits: two's-complement multiplicand.
REQ-007 SHALL have port mp, input, WIDTH bits: two's-complement multiplier.
REQ-008 SHALL have port spm_x, output, WIDTH bits: parallel multiplicand to the serial-parallel multiplier.
REQ-009 SHALL have port spm_y, output, 1 bit: serial multiplier bit, LSB first.
REQ-010 SHALL have port spm_rst_n, output, 1 bit: active-low clear for the multiplier stage.
REQ-011 SHALL have port spm_p, input, 1 bit: serial product bit returned by the multiplier.
REQ-012 SHALL have port prod, output, 2*WIDTH bits: assembled signed product.
REQ-013 SHALL have port out_valid, output, 1 bit: prod holds a valid result.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes prod.

Function
REQ-015 SHALL implement four states:
- IDLE
- CLEAR
- RUN
- DONE
REQ-016 IDLE: in_ready=1; on in_valid=1, SHALL latch mc and mp into internal registers and go to CLEAR.
REQ-017 CLEAR: SHALL last exactly one cycle; spm_rst_n=0 only in this state, driven from a register (glitch-free); then RUN with cnt=0.
REQ-018 RUN: SHALL keep cnt from 0 to 2*WIDTH inclusive, one step per cycle, which is 2*WIDTH+1 cycles.
REQ-019 RUN: spm_y SHALL equal bit cnt of mp sign-extended to 2*WIDTH bits for cnt<2*WIDTH, and 0 at cnt=2*WIDTH.
REQ-020 spm_x SHALL equal the latched mc from CLEAR through DONE, and 0 in IDLE.
REQ-021 RUN: at cnt>=1, each cycle SHALL shift spm_p in at the MSB (prod <= {spm_p, prod[2W-1:1]}), so product bit k is captured at cnt=k+1.
REQ-022 At cnt=2*WIDTH SHALL capture the final bit and go to DONE.
REQ-023 DONE: out_valid=1 and prod stable; go to IDLE on out_ready=1.
REQ-024 out_valid SHALL rise on exactly the 2*WIDTH+3rd rising edge after the accepting edge, which is edge 67 for WIDTH=32.
REQ-025 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored, with no queuing.
REQ-026 When out_ready=1 and in_valid=1 arrive together in DONE, SHALL go to IDLE only; the new pair is accepted on the next edge at the earliest.
REQ-027 out_ready outside DONE SHALL have no effect.
REQ-028 prod SHALL be cleared to 0 on entering CLEAR.
REQ-029 cnt SHALL be ceil(log2(2*WIDTH+1)) bits wide and SHALL never wrap.

Reset
REQ-030 While rst_n=0, SHALL asynchronously force:
- state=IDLE
- cnt=0
- prod=0
- spm_x=0
- spm_y=0
- out_valid=0
- spm_rst_n=0
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 from the first edge after release.
REQ-032 spm_rst_n SHALL be 1 from the first edge after release.
REQ-033 Reset asserted mid-RUN or in DONE SHALL discard the operation; no partial out_valid pulse.

Structure
REQ-034 Package spm_pkg SHALL hold:
- the state enumeration (IDLE/CLEAR/RUN/DONE)
- the default WIDTH constant
- the counter-width constant derived from it
REQ-035 The serial-to-parallel product capture (shift register plus capture enable) SHALL be one sub-module, spm_deser; the FSM and counter stay in spm_seq.
REQ-036 The multiplier itself SHALL NOT be instantiated inside spm_seq; the bench connects the two.

Verification
REQ-037 Bench SHALL cover, with spm_seq connected to the serial-parallel multiplier at WIDTH=32:
- mc=5, mp=3 -> prod=0x0000_0000_0000_000F; out_valid exactly 67 edges after accept.
- mc=50, mp=-50 -> prod=0xFFFF_FFFF_FFFF_F63C (-2500).
- mc=mp=0x8000_0000 -> prod=0x4000_0000_0000_0000.
- Result held with out_ready=0 for 10 cycles, in_valid=1 throughout -> prod and out_valid stable, in_ready=0, no second accept; release -> IDLE, then accept.
- rst_n pulsed low at cnt=20 of RUN -> immediate IDLE, out_valid never asserted, next op mc=7, mp=-1 -> prod=-7 (0xFFFF_FFFF_FFFF_FFF9).
- Back-to-back ops with out_ready tied 1 -> one IDLE cycle between DONE and next accept; spm_rst_n low exactly one cycle per op.
